// File: rtl/window_pkg.sv
// -----------------------------------------------------------------------------
// window_pkg
//   Shared definitions for window_reader: FSM state type and the default
//   values of the reader's parameters.
// -----------------------------------------------------------------------------
package window_pkg;

  localparam int unsigned SIZE_DEF      = 16;  // word width in bits
  localparam int unsigned MEM_SIZE_DEF  = 8;   // buffer depth == frame length
  localparam int unsigned PAR_WRITE_DEF = 2;   // words committed per wr_done
  localparam int unsigned PAR_READ_DEF  = 3;   // words per emitted window
  localparam int unsigned STRIDE_DEF    = 1;   // raddr step between windows

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    OUT     = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/window_reader.sv
// -----------------------------------------------------------------------------
// window_reader
//   Reads overlapping windows of PAR_READ words out of a frame buffer that a
//   writer fills PAR_WRITE words at a time. A window at raddr is emitted once
//   enough words have been written to cover it; after the last window of the
//   frame the buffer is handed back to the writer with a one-cycle buf_free.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_done    in   writer committed PAR_WRITE words this cycle
//   mem_dout   in   combinational buffer data at raddr (word i at [i*SIZE +: SIZE])
//   raddr      out  registered buffer read address
//   out_data   out  registered window
//   out_valid  out  out_data holds a valid window
//   out_ready  in   consumer accepts the window
//   buf_free   out  one-cycle pulse when the buffer is released
//   level      out  words written in the current frame (saturates at MEM_SIZE)
//   ovf        out  sticky: wr_done arrived while the frame was already full
//   win_cnt    out  (WINDOW_READER_STATS_EN only) wrapping window handshake count
//
// Build option
//   WINDOW_READER_STATS_EN  adds the win_cnt output and its counter.
// -----------------------------------------------------------------------------
module window_reader
  import window_pkg::*;
#(
  parameter int unsigned SIZE        = SIZE_DEF,
  parameter int unsigned MEM_SIZE    = MEM_SIZE_DEF,
  parameter int unsigned PAR_WRITE   = PAR_WRITE_DEF,
  parameter int unsigned PAR_READ    = PAR_READ_DEF,
  parameter int unsigned STRIDE      = STRIDE_DEF,
  parameter int unsigned ADDRES_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_done,
  input  logic [SIZE*PAR_READ-1:0] mem_dout,
  output logic [ADDRES_SIZE-1:0]   raddr,
  output logic [SIZE*PAR_READ-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     buf_free,
  output logic [ADDRES_SIZE:0]     level,
  output logic                     ovf
`ifdef WINDOW_READER_STATS_EN
  ,
  output logic [15:0]              win_cnt
`endif
);

  typedef logic [ADDRES_SIZE-1:0]   addr_t;
  typedef logic [ADDRES_SIZE:0]     level_t;
  typedef logic [SIZE*PAR_READ-1:0] win_t;

  state_e state_q, state_d;
  addr_t  raddr_q, raddr_d;
  win_t   data_q,  data_d;
  level_t level_q, level_d;
  logic   ovf_q,   ovf_d;

  logic win_ready;  // current window fully written
  logic more_win;   // another window fits after this one
  logic handshake;

  assign win_ready = (32'(raddr_q) + PAR_READ) <= 32'(level_q);
  assign more_win  = (32'(raddr_q) + STRIDE + PAR_READ) <= MEM_SIZE;
  assign handshake = (state_q == OUT) && out_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (win_ready) state_d = OUT;
      OUT:     if (out_ready) state_d = more_win ? FILL : RELEASE;
      RELEASE: state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs decode the registered state only, so out_valid never sees out_ready.
  always_comb begin
    out_valid = (state_q == OUT);
    buf_free  = (state_q == RELEASE);
  end

  // ------------------------------------------------------- read datapath
  always_comb begin
    raddr_d = raddr_q;
    data_d  = data_q;
    if ((state_q == FILL) && win_ready) begin
      data_d = mem_dout;
    end
    if (handshake && more_win) begin
      raddr_d = raddr_q + addr_t'(STRIDE);
    end
    if (state_q == RELEASE) begin
      raddr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
      data_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      data_q  <= data_d;
    end
  end

  // ------------------------------------------------- level / ovf tracker
  // A write landing in the RELEASE cycle belongs to the next frame.
  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    if (state_q == RELEASE) begin
      level_d = wr_done ? level_t'(PAR_WRITE) : '0;
    end else if (wr_done) begin
      if (32'(level_q) >= MEM_SIZE) begin
        ovf_d = 1'b1;
      end else if ((32'(level_q) + PAR_WRITE) >= MEM_SIZE) begin
        level_d = level_t'(MEM_SIZE);
      end else begin
        level_d = level_q + level_t'(PAR_WRITE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign raddr    = raddr_q;
  assign out_data = data_q;
  assign level    = level_q;
  assign ovf      = ovf_q;

`ifdef WINDOW_READER_STATS_EN
  logic [15:0] win_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
    end else if (handshake) begin
      win_cnt_q <= win_cnt_q + 16'd1;
    end
  end

  assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_window_reader.sv
// -----------------------------------------------------------------------------
// tb_window_reader
//   Two readers share clock and reset: dut1 with default parameters and dut2
//   with STRIDE=2. Each has its own frame memory. Accepted windows are logged
//   at the falling edge and compared with the windows a frame must produce:
//   window k starts at k*STRIDE and carries mem[k*STRIDE .. k*STRIDE+2].
// -----------------------------------------------------------------------------
module tb_window_reader;

  localparam int unsigned SZ = 16;
  localparam int unsigned MS = 8;
  localparam int unsigned PR = 3;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = SZ * PR;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          wr1, or1, ov1, bf1, ovf1;
  logic [DW-1:0] md1, od1;
  logic [AW-1:0] ra1;
  logic [AW:0]   lv1;
  logic          wr2, or2, ov2, bf2, ovf2;
  logic [DW-1:0] md2, od2;
  logic [AW-1:0] ra2;
  logic [AW:0]   lv2;
`ifdef WINDOW_READER_STATS_EN
  logic [15:0]   wc1, wc2;
`endif

  logic [SZ-1:0] mem1 [MS];
  logic [SZ-1:0] mem2 [MS];

  int checks = 0;
  int errors = 0;

  int unsigned   qa1[$], qa2[$];
  logic [DW-1:0] qd1[$], qd2[$];

  window_reader dut1 (
    .clk(clk), .rst_n(rst_n), .wr_done(wr1), .mem_dout(md1), .raddr(ra1),
    .out_data(od1), .out_valid(ov1), .out_ready(or1), .buf_free(bf1),
    .level(lv1), .ovf(ovf1)
`ifdef WINDOW_READER_STATS_EN
    , .win_cnt(wc1)
`endif
  );

  window_reader #(.STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_done(wr2), .mem_dout(md2), .raddr(ra2),
    .out_data(od2), .out_valid(ov2), .out_ready(or2), .buf_free(bf2),
    .level(lv2), .ovf(ovf2)
`ifdef WINDOW_READER_STATS_EN
    , .win_cnt(wc2)
`endif
  );

  // Combinational buffers
  always_comb begin
    md1 = '0;
    md2 = '0;
    for (int unsigned i = 0; i < PR; i++) begin
      md1[i*SZ +: SZ] = mem1[(32'(ra1) + i) % MS];
      md2[i*SZ +: SZ] = mem2[(32'(ra2) + i) % MS];
    end
  end

  // Handshake monitor
  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      qa1.push_back(32'(ra1));
      qd1.push_back(od1);
    end
    if (rst_n && ov2 && or2) begin
      qa2.push_back(32'(ra2));
      qd2.push_back(od2);
    end
  end

  function automatic logic [DW-1:0] win(input logic [SZ-1:0] m [MS], input int unsigned a);
    logic [DW-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < PR; i++) w[i*SZ +: SZ] = m[a + i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input int sel);
    for (int unsigned i = 0; i < MS; i++) begin
      if (sel == 1) mem1[i] = 16'($urandom);
      else          mem2[i] = 16'($urandom);
    end
  endtask

  task automatic pulse(input int sel);
    if (sel == 1) wr1 = 1'b1; else wr2 = 1'b1;
    tick;
    wr1 = 1'b0;
    wr2 = 1'b0;
    tick;
  endtask

  // Returns just after the edge that entered RELEASE (buf_free high).
  task automatic wait_release(input int sel, input bit rnd);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (n < 300 && !seen) begin
      if (rnd) begin
        if (sel == 1) or1 = 1'($urandom_range(1, 0));
        else          or2 = 1'($urandom_range(1, 0));
      end
      tick;
      n++;
      seen = (sel == 1) ? bf1 : bf2;
    end
    chk($sformatf("release_seen%0d", sel), 64'(seen), 64'd1);
  endtask

  task automatic check_frame(input int sel);
    int unsigned stride, nwin, got;
    stride = (sel == 1) ? 1 : 2;
    nwin   = (MS - PR) / stride + 1;
    got    = (sel == 1) ? qa1.size() : qa2.size();
    chk($sformatf("win_count%0d", sel), 64'(got), 64'(nwin));
    for (int unsigned k = 0; k < nwin && k < got; k++) begin
      if (sel == 1) begin
        chk($sformatf("win_addr1[%0d]", k), 64'(qa1[k]), 64'(k * stride));
        chk($sformatf("win_data1[%0d]", k), 64'(qd1[k]), 64'(win(mem1, k * stride)));
      end else begin
        chk($sformatf("win_addr2[%0d]", k), 64'(qa2[k]), 64'(k * stride));
        chk($sformatf("win_data2[%0d]", k), 64'(qd2[k]), 64'(win(mem2, k * stride)));
      end
    end
    if (sel == 1) begin qa1.delete(); qd1.delete(); end
    else          begin qa2.delete(); qd2.delete(); end
  endtask

  initial begin
    bit found;
    logic [DW-1:0] held;
    rst_n = 1'b1;
    wr1 = 1'b0; or1 = 1'b0; wr2 = 1'b0; or2 = 1'b0;
    fill_mem(1);
    fill_mem(2);

    // Reset values, asserted before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(ov1), 64'd0);
    chk("rst_raddr", 64'(ra1), 64'd0);
    chk("rst_level", 64'(lv1), 64'd0);
    chk("rst_data",  64'(od1), 64'd0);
    chk("rst_buf_free", 64'(bf1), 64'd0);
    chk("rst_ovf",   64'(ovf1), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    // Frame 1: first window needs two writes; then a 5-cycle stall
    qa1.delete(); qd1.delete();
    wr1 = 1'b1; tick; wr1 = 1'b0;
    chk("one_write_level", 64'(lv1), 64'd2);
    repeat (3) tick;
    chk("one_write_no_valid", 64'(ov1), 64'd0);
    wr1 = 1'b1; tick; wr1 = 1'b0;
    chk("two_write_level", 64'(lv1), 64'd4);
    chk("two_write_not_yet", 64'(ov1), 64'd0);
    tick;
    chk("first_valid", 64'(ov1), 64'd1);
    chk("first_data", 64'(od1), 64'(win(mem1, 0)));
    held = od1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("stall_valid%0d", i), 64'(ov1), 64'd1);
      chk($sformatf("stall_data%0d", i), 64'(od1), 64'(held));
      chk($sformatf("stall_raddr%0d", i), 64'(ra1), 64'd0);
    end
    or1 = 1'b1;
    tick;
    chk("after_hs_raddr", 64'(ra1), 64'd1);
    chk("after_hs_valid", 64'(ov1), 64'd0);
    pulse(1);
    pulse(1);
    wait_release(1, 1'b0);
    chk("release_raddr_f1", 64'(ra1), 64'd5);
    check_frame(1);
    tick;
    chk("post_release_buf_free", 64'(bf1), 64'd0);
    chk("post_release_raddr", 64'(ra1), 64'd0);
    chk("post_release_level", 64'(lv1), 64'd0);
    chk("post_release_valid", 64'(ov1), 64'd0);

    // Frame 2: four writes, consumer always ready; write during RELEASE
    fill_mem(1);
    repeat (4) pulse(1);
    wait_release(1, 1'b0);
    check_frame(1);
    fill_mem(1);
    wr1 = 1'b1; tick; wr1 = 1'b0;
    chk("release_write_level", 64'(lv1), 64'd2);
    chk("release_write_raddr", 64'(ra1), 64'd0);

    // Frame 3: fill the frame under stall, then overflow it
    or1 = 1'b0;
    repeat (3) pulse(1);
    chk("full_level", 64'(lv1), 64'd8);
    chk("full_no_ovf", 64'(ovf1), 64'd0);
    wr1 = 1'b1; tick; wr1 = 1'b0;
    chk("ovf_set", 64'(ovf1), 64'd1);
    chk("ovf_level", 64'(lv1), 64'd8);
    or1 = 1'b1;
    wait_release(1, 1'b0);
    check_frame(1);
    tick;
    chk("ovf_sticky", 64'(ovf1), 64'd1);
    chk("f3_level_clear", 64'(lv1), 64'd0);

    // Frame 4: reset while window 3 is pending
    fill_mem(1);
    repeat (3) pulse(1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ov1 && ra1 == 3'd3) found = 1'b1;
      else tick;
    end
    or1 = 1'b0;
    chk("reached_raddr3", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ov1), 64'd0);
    chk("mid_rst_raddr", 64'(ra1), 64'd0);
    chk("mid_rst_level", 64'(lv1), 64'd0);
    chk("mid_rst_ovf",   64'(ovf1), 64'd0);
    chk("mid_rst_accepted", 64'(qa1.size()), 64'd3);
    qa1.delete(); qd1.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick;
    chk("resume_valid", 64'(ov1), 64'd0);
    chk("resume_level", 64'(lv1), 64'd0);

    // Frame 5: random write gaps and random consumer stalls
    fill_mem(1);
    for (int i = 0; i < 4; i++) begin
      or1 = 1'($urandom_range(1, 0));
      wr1 = 1'b1; tick; wr1 = 1'b0;
      repeat ($urandom_range(2, 0)) begin
        or1 = 1'($urandom_range(1, 0));
        tick;
      end
    end
    wait_release(1, 1'b1);
    chk("release_raddr_f5", 64'(ra1), 64'd5);
    check_frame(1);
    or1 = 1'b1;
    tick;
`ifdef WINDOW_READER_STATS_EN
    chk("win_cnt1", 64'(wc1), 64'd6);
`endif

    // dut2, STRIDE=2: two frames with random stalls
    for (int f = 0; f < 2; f++) begin
      fill_mem(2);
      repeat (4) pulse(2);
      wait_release(2, 1'b1);
      chk($sformatf("release_raddr2_f%0d", f), 64'(ra2), 64'd4);
      check_frame(2);
      or2 = 1'b1;
      tick;
      chk($sformatf("post_release2_raddr_f%0d", f), 64'(ra2), 64'd0);
`ifdef WINDOW_READER_STATS_EN
      chk($sformatf("win_cnt2_f%0d", f), 64'(wc2), 64'(3 * (f + 1)));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_reader.md
WINDOW_READER -- requirements
Module: window_reader

Interface
REQ-001 SHALL have parameter SIZE, default 16, meaning the word width in bits.
REQ-002 SHALL have parameter MEM_SIZE, default 8, meaning the buffer depth in words, which is also the frame length.
REQ-003 SHALL have parameter PAR_WRITE, default 2, meaning the words the writer commits per write cycle.
REQ-004 SHALL have parameter PAR_READ, default 3, meaning the words per emitted window.
REQ-005 SHALL have parameter STRIDE, default 1, meaning the raddr step between consecutive windows.
REQ-006 SHALL have parameter ADDRES_SIZE, default $clog2(MEM_SIZE), meaning the address width.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port wr_done, input, 1 bit: the writer committed PAR_WRITE words this cycle.
REQ-010 SHALL have port mem_dout, input, SIZE*PAR_READ bits: combinational buffer read data at raddr, word i in bits [i*SIZE +: SIZE].
REQ-011 SHALL have port raddr, output, ADDRES_SIZE bits: registered buffer read address.
REQ-012 SHALL have port out_data, output, SIZE*PAR_READ bits: registered window.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a valid window.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts the window.
REQ-015 SHALL have port buf_free, output, 1 bit: one-cycle pulse when the buffer is released to the writer.
REQ-016 SHALL have port level, output, ADDRES_SIZE+1 bits: count of words written in the current frame.
REQ-017 SHALL have port ovf, output, 1 bit: sticky flag set by a write into a full frame.

Function
REQ-018 SHALL implement the states FILL, OUT and RELEASE.
REQ-019 SHALL add PAR_WRITE to level on each accepted wr_done, saturating at MEM_SIZE; a wr_done received while level==MEM_SIZE SHALL set ovf and leave level unchanged.
REQ-020 SHALL, in FILL, move to OUT when raddr+PAR_READ <= level, registering out_data <= mem_dout on that same edge; out_valid is therefore 1 cycle after the condition first holds.
REQ-021 SHALL, in OUT, hold out_valid and out_data stable until out_valid && out_ready.
REQ-022 SHALL, on a handshake where raddr+STRIDE+PAR_READ <= MEM_SIZE, increment raddr by STRIDE and return to FILL.
REQ-023 SHALL, on a handshake for the last window, enter RELEASE.
REQ-024 SHALL, in RELEASE (exactly one cycle), assert buf_free, clear raddr to 0 and level to 0, then enter FILL.
REQ-025 SHALL count a wr_done coinciding with RELEASE toward the new frame, giving level = PAR_WRITE.
REQ-026 SHALL process the window count (MEM_SIZE-PAR_READ)/STRIDE+1 per frame, with integer division.
REQ-027 SHALL deassert out_valid in FILL and RELEASE.
REQ-028 SHALL never let out_valid depend combinationally on out_ready.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=FILL, raddr=0, level=0, out_valid=0, out_data=0, buf_free=0 and ovf=0, regardless of clk.
REQ-030 SHALL, on reset mid-frame, discard any pending window with no handshake, and resume in FILL at the first rising edge after rst_n=1.

Configuration
REQ-031 SHALL, when WINDOW_READER_STATS_EN is defined, add output win_cnt (16 bits, reset 0), which increments on each window handshake, wraps at 16'hFFFF to 0, and is not cleared by RELEASE.
REQ-032 SHALL, without WINDOW_READER_STATS_EN, omit the win_cnt port and its logic entirely, with all other behaviour identical.

Structure
REQ-033 SHALL place the state enum type (FILL/OUT/RELEASE) and the parameter defaults in shared package window_pkg.
REQ-034 SHALL contain no sub-module; the level/ovf tracker is an always block in window_reader, and the buffer is instantiated outside by the parent alongside it.

Verification
REQ-035 SHALL verify: defaults, out_ready=1, 4 wr_done pulses 1 cycle apart -> windows at raddr 0..5, then buf_free pulse, raddr=0, level=0.
REQ-036 SHALL verify: 1 wr_done only (level=2) -> out_valid stays 0; a 2nd wr_done -> out_valid=1 one cycle later with out_data = mem[0..2].
REQ-037 SHALL verify: out_ready=0 for 5 cycles during OUT -> out_valid=1 and out_data unchanged throughout; raddr advances only after out_ready=1.
REQ-038 SHALL verify: wr_done in the RELEASE cycle -> level=2 next cycle; a 5th wr_done in a full frame -> ovf=1 and level=8.
REQ-039 SHALL verify: rst_n low mid-OUT (raddr=3) -> out_valid=0, raddr=0, level=0 asynchronously.
REQ-040 SHALL verify: STRIDE=2 with WINDOW_READER_STATS_EN -> windows at raddr 0,2,4, buf_free, and win_cnt=3.
